// File: rtl/fifo_skew_scheduler_if.sv
// Handshake bundle between the job controller, the row FIFO bank and the skew scheduler.
// master = controller/FIFO side, slave = scheduler.
interface fifo_skew_scheduler_if #(
    parameter int ROWS  = 4,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [ROWS-1:0]  fifo_empty;
    logic [ROWS-1:0]  rd_en;
    logic [ROWS-1:0]  row_valid;
    logic             busy;
    logic             done;
    logic             stalled;
    logic             timeout;

    modport master (
        output start, len, fifo_empty,
        input  rd_en, row_valid, busy, done, stalled, timeout
    );

    modport slave (
        input  start, len, fifo_empty,
        output rd_en, row_valid, busy, done, stalled, timeout
    );
endinterface

// File: rtl/fifo_skew_scheduler.sv
// Diagonal-skew read sequencer for a bank of row FIFOs feeding a systolic array.
// Optional feature macro: STALL_TIMEOUT_EN (abort a job after 2^TO_W-1 consecutive stalled cycles).
module fifo_skew_scheduler #(
    parameter int ROWS  = 4,
    parameter int LEN_W = 8,
    parameter int TO_W  = 8
) (
    input logic                  clk,
    input logic                  rst,
    fifo_skew_scheduler_if.slave bus
);
    // Step width covers len_q+ROWS-2 and r+len_q without wrap.
    localparam int SW = (LEN_W + 1 > $clog2(ROWS) + 2) ? LEN_W + 1 : $clog2(ROWS) + 2;

    if (ROWS < 1 || TO_W < 1) begin : g_param_check
        $error("fifo_skew_scheduler: ROWS and TO_W must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [SW-1:0]    last_step;
    logic [LEN_W-1:0] len_q;
    logic [ROWS-1:0]  sched;
    logic [ROWS-1:0]  rd_en_c;
    logic [ROWS-1:0]  row_valid_q;
    logic             stall;
    logic             accept;
    logic             to_hit;

    assign accept    = (state_q == IDLE) && bus.start;
    assign last_step = SW'(len_q) + SW'(ROWS) - SW'(2);

    always_comb begin
        sched = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            sched[r] = (state_q == RUN) && (step_q >= SW'(r)) && (step_q < SW'(r) + SW'(len_q));
        end
    end

    // A stall on any scheduled row freezes every row so the diagonal skew is never broken.
    assign stall   = |(sched & bus.fifo_empty);
    assign rd_en_c = (stall || rst) ? '0 : sched;

`ifdef STALL_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_MAX  = '1;
    localparam logic [TO_W-1:0] TO_LAST = TO_MAX - TO_W'(1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_q;

    assign to_hit = stall && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else if (accept) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else if (stall) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (to_hit) to_q <= 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign bus.timeout = to_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? DONE : RUN;
                    step_d  = '0;
                end
            end
            RUN: begin
                if (to_hit) begin
                    state_d = DONE;
                end else if (!stall) begin
                    if (step_q == last_step) state_d = DRAIN;
                    else                     step_d  = step_q + SW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q      <= '0;
            len_q       <= '0;
            row_valid_q <= '0;
        end else begin
            step_q      <= step_d;
            row_valid_q <= rd_en_c;
            if (accept) len_q <= bus.len;
        end
    end

    assign bus.rd_en     = rd_en_c;
    assign bus.row_valid = row_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.stalled   = stall;
endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// Self-checking bench for fifo_skew_scheduler (ROWS=4, LEN_W=8); a job-level model is checked every cycle.
module tb_fifo_skew_scheduler;
    localparam int ROWS  = 4;
    localparam int LEN_W = 8;
`ifdef STALL_TIMEOUT_EN
    localparam int TO_W  = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO_W  = 8;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    fifo_skew_scheduler_if #(.ROWS(ROWS), .LEN_W(LEN_W)) bus ();

    fifo_skew_scheduler #(.ROWS(ROWS), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Job-level model: progress k counts non-frozen RUN cycles; tail counts DRAIN/DONE cycles left.
    bit       m_run = 1'b0;
    int       m_tail = 0;
    int       m_k = 0;
    int       m_len = 0;
    int       m_sc = 0;
    bit       m_to = 1'b0;
    logic [3:0] m_prev_rd = '0;
    int       rd_cnt [ROWS];

    always @(negedge clk) begin : cmp
        logic [3:0] e_sched;
        logic       e_stall;
        logic [3:0] e_rd;
        if (chk_en) begin
            e_sched = '0;
            for (int r = 0; r < ROWS; r++)
                if (m_run && r <= m_k && m_k < r + m_len) e_sched[r] = 1'b1;
            e_stall = |(e_sched & bus.fifo_empty);
            e_rd    = (rst || e_stall) ? 4'h0 : e_sched;

            chk("rd_en",     bus.rd_en,     e_rd);
            chk("row_valid", bus.row_valid, m_prev_rd);
            chk("busy",      bus.busy,      m_run || m_tail > 0);
            chk("done",      bus.done,      m_tail == 1);
            chk("stalled",   bus.stalled,   e_stall);
            chk("timeout",   bus.timeout,   m_to);

            for (int r = 0; r < ROWS; r++) rd_cnt[r] += int'(bus.rd_en[r]);
            if (m_tail == 1 && !m_to && !rst) begin
                for (int r = 0; r < ROWS; r++) chk($sformatf("reads_row%0d", r), rd_cnt[r], m_len);
            end

            m_prev_rd = e_rd;
            if (rst) begin
                m_run = 0; m_tail = 0; m_k = 0; m_len = 0; m_sc = 0; m_to = 0; m_prev_rd = '0;
                for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
            end else if (!m_run && m_tail == 0) begin
                if (bus.start) begin
                    m_len = int'(bus.len); m_k = 0; m_sc = 0; m_to = 0;
                    for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
                    if (m_len == 0) m_tail = 1;
                    else            m_run = 1;
                end
            end else if (m_run) begin
                if (e_stall) begin
                    m_sc++;
                    if (TO_EN && m_sc == (1 << TO_W) - 1) begin
                        m_run = 0; m_tail = 1; m_to = 1;
                    end
                end else begin
                    m_sc = 0;
                    m_k++;
                    if (m_k == m_len + ROWS - 1) begin
                        m_run = 0; m_tail = 2;
                    end
                end
            end else begin
                m_tail--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] l, output int t0);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int exp_lat, input string nm);
        int lat;
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
        chk(nm, lat, exp_lat);
    endtask

    logic [3:0] exp_rd [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0, t1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.fifo_empty = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset mid-job, with a start presented during reset
        launch(8'd5, t0);
        repeat (3) tick();
        rst = 1'b1; bus.start = 1'b1; bus.len = 8'd4;
        tick(); tick();
        rst = 1'b0; bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s1_busy", bus.busy, 1'b0);
            chk("s1_rd",   bus.rd_en, 4'h0);
            tick();
        end

        // len=3, no stalls: literal skew pattern
        launch(8'd3, t0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) chk("s2_rd", bus.rd_en, exp_rd[i]);
            else       chk("s2_rd_drain", bus.rd_en, 4'h0);
            if (i >= 1) chk("s2_rv", bus.row_valid, exp_rd[i-1]);
        end
        wait_done(t0, 8, "s2_done_lat");
        tick();

        // len=0: straight to DONE
        launch(8'd0, t0);
        wait_done(t0, 1, "s3_done_lat");
        chk("s3_busy_done", bus.busy, 1'b1);
        tick();
        @(negedge clk);
        chk("s3_busy_after", bus.busy, 1'b0);
        tick();

        // len=3 with row 2 empty for 4 cycles at step 2
        launch(8'd3, t0);
        tick(); tick();
        bus.fifo_empty = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s4_stalled", bus.stalled, 1'b1);
            chk("s4_rd_frozen", bus.rd_en, 4'h0);
            tick();
        end
        bus.fifo_empty = 4'b0000;
        @(negedge clk);
        chk("s4_resume", bus.rd_en, 4'h7);
        wait_done(t0, 12, "s4_done_lat");
        tick();

        // start while busy is ignored
        launch(8'd3, t0);
        tick();
        bus.start = 1'b1; bus.len = 8'd9;
        tick();
        bus.start = 1'b0;
        wait_done(t0, 8, "s5_done_lat");
        tick();
        launch(8'd2, t1);
        wait_done(t1, 7, "s5_next_lat");
        tick();

`ifdef STALL_TIMEOUT_EN
        // Permanent stall trips the timeout
        bus.fifo_empty = 4'hF;
        launch(8'd3, t0);
        wait_done(t0, 16, "s6_abort_lat");
        chk("s6_timeout_set", bus.timeout, 1'b1);
        tick();
        bus.fifo_empty = 4'h0;
        @(negedge clk);
        chk("s6_timeout_sticky", bus.timeout, 1'b1);
        tick();
        launch(8'd1, t1);
        @(negedge clk);
        chk("s6_timeout_clear", bus.timeout, 1'b0);
        wait_done(t1, 6, "s6_next_lat");
        tick();
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
